adc_spi_reader: RTL and testbench

//  SPI capture front-end for the on-board dual-channel 14-bit ADC. It is the receive

---
 rtl/adc_spi_reader.sv | 166 ++++++++++++++++
 tb/tb_adc_spi_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader.sv
// SPI capture front-end for the dual-channel 14-bit ADC: periodic conversion start,
// 34-bit frame shift-in, and a valid/ack handshake toward the audio path.
module adc_spi_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1134
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        spi_miso,
    output logic        ad_conv,
    output logic        spi_sck,
    output logic [13:0] ch0_data,
    output logic [13:0] ch1_data,
    output logic        sample_valid,
    input  logic        sample_ack,
    output logic        overrun
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int CW = $clog2(2 * CLK_DIV) + 1;

    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [5:0]    BIT_LAST  = 6'd33;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] per_q, per_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [13:0]   sh0_q, sh0_d;
    logic [13:0]   sh1_q, sh1_d;
    logic [13:0]   ch0_q, ch0_d;
    logic [13:0]   ch1_q, ch1_d;
    logic          conv_q, conv_d;
    logic          sck_q, sck_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          tick;

    assign tick = enable && (per_q == PER_LAST);

    always_comb begin
        // NOTE: every *_d starts from its *_q so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        ch0_d   = ch0_q;
        ch1_d   = ch1_q;
        conv_d  = conv_q;
        sck_d   = sck_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (!enable || per_q == PER_LAST) begin
            per_d = '0;
        end else begin
            per_d = per_q + PW'(1);
        end

        // An accepted ack is overridden below when a new sample lands in the same cycle.
        if (valid_q && sample_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    conv_d  = 1'b1;
                end
            end
            CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    conv_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (bit_q >= 6'd2 && bit_q <= 6'd15) begin
                            sh0_d = {sh0_q[12:0], spi_miso};
                        end
                        if (bit_q >= 6'd18 && bit_q <= 6'd31) begin
                            sh1_d = {sh1_q[12:0], spi_miso};
                        end
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = DONE;
                        end else begin
                            bit_d = bit_q + 6'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                ch0_d   = sh0_q;
                ch1_d   = sh1_q;
                valid_d = 1'b1;
                if (valid_q && !sample_ack) begin
                    ovr_d = 1'b1;
                end
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            ch0_q   <= '0;
            ch1_q   <= '0;
            conv_q  <= 1'b0;
            sck_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            ch0_q   <= ch0_d;
            ch1_q   <= ch1_d;
            conv_q  <= conv_d;
            sck_q   <= sck_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign ad_conv      = conv_q;
    assign spi_sck      = sck_q;
    assign ch0_data     = ch0_q;
    assign ch1_data     = ch1_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Testbench for adc_spi_reader: a serial ADC model plus a transaction-level reference
// for the sample words, valid/overrun flags and frame timing.
module tb_adc_spi_reader;

    localparam int CLK_DIV = 4;
    localparam int SP      = 1134;
    localparam int LAT     = 70 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        spi_miso;
    logic        sample_ack;
    logic        ad_conv;
    logic        spi_sck;
    logic [13:0] ch0_data;
    logic [13:0] ch1_data;
    logic        sample_valid;
    logic        overrun;

    adc_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .spi_miso     (spi_miso),
        .ad_conv      (ad_conv),
        .spi_sck      (spi_sck),
        .ch0_data     (ch0_data),
        .ch1_data     (ch1_data),
        .sample_valid (sample_valid),
        .sample_ack   (sample_ack),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Event monitor, sampled 1 time unit after each rising edge.
    int   conv_n = 0, conv_cyc = 0, conv_width = 0;
    int   vrise_n = 0, vrise_cyc = 0;
    int   sck_n = 0;
    logic ad_p = 1'b0, v_p = 1'b0;
    always @(posedge clk) begin
        #1;
        if (ad_conv && !ad_p) begin
            conv_n++;
            conv_cyc = cyc;
        end
        if (!ad_conv && ad_p) conv_width = cyc - conv_cyc;
        if (sample_valid && !v_p) begin
            vrise_n++;
            vrise_cyc = cyc;
        end
        ad_p = ad_conv;
        v_p  = sample_valid;
    end
    always @(posedge spi_sck) sck_n++;

    // ADC model: frame snapshot on ad_conv rise, next bit driven on each sck fall.
    logic [13:0] adc_ch0 = '0, adc_ch1 = '0;
    logic [1:0]  junk = 2'b11;
    logic [33:0] frame = '0;
    int          bi = 0;
    always @(posedge ad_conv or negedge spi_sck) begin
        if (ad_conv && !spi_sck) begin
            frame    = {junk, adc_ch0, junk, adc_ch1, junk};
            bi       = 0;
            spi_miso = frame[33];
        end else begin
            bi++;
            if (bi < 34) spi_miso = frame[33-bi];
        end
    end

    // Reference model of the consumer-visible state.
    logic [13:0] exp_ch0 = '0, exp_ch1 = '0;
    logic        exp_valid = 1'b0, exp_ovr = 1'b0;

    task automatic frame_done(input logic ack_now);
        if (exp_valid && !ack_now) exp_ovr = 1'b1;
        exp_valid = 1'b1;
        exp_ch0   = adc_ch0;
        exp_ch1   = adc_ch1;
    endtask

    task automatic accept();
        exp_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ch0"}, 32'(ch0_data), 32'(exp_ch0));
        check({tag, "_ch1"}, 32'(ch1_data), 32'(exp_ch1));
        check({tag, "_valid"}, 32'(sample_valid), 32'(exp_valid));
        check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic wait_conv(input string tag);
        int start = conv_n;
        int k = 0;
        while (conv_n == start && k < 3 * SP) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_conv_timeout"}, 32'(conv_n != start), 32'd1);
    endtask

    task automatic wait_vrise(input string tag);
        int start = vrise_n;
        int k = 0;
        while (vrise_n == start && k < 3 * SP) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid_timeout"}, 32'(vrise_n != start), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic ack_pulse();
        sample_ack = 1'b1;
        @(negedge clk);
        sample_ack = 1'b0;
        if (exp_valid) accept();
    endtask

    task automatic new_frame();
        adc_ch0 = 14'($urandom) | 14'd1;
        adc_ch1 = 14'($urandom);
        junk    = 2'($urandom);
    endtask

    initial begin
        int en_cyc, c0, a, r_cyc, sck_base, n, k;
        rst        = 1'b1;
        enable     = 1'b0;
        spi_miso   = 1'b0;
        sample_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ad_conv", 32'(ad_conv), 32'd0);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check_outputs("rst");

        // Basic frame with fixed words and gap bits forced high.
        rst = 1'b0;
        @(negedge clk);
        adc_ch0 = 14'h1ABC;
        adc_ch1 = 14'h2001;
        junk    = 2'b11;
        enable  = 1'b1;
        en_cyc  = cyc;
        wait_conv("first");
        check("first_tick_delay", 32'(conv_cyc - en_cyc), 32'(SP));
        c0       = conv_cyc;
        sck_base = sck_n;
        wait_vrise("basic");
        check("latency", 32'(vrise_cyc - conv_cyc), 32'(LAT));
        check("conv_width", 32'(conv_width), 32'(2 * CLK_DIV));
        check("sck_edges", 32'(sck_n - sck_base), 32'd34);
        frame_done(1'b0);
        check_outputs("basic");

        ack_pulse();
        check_outputs("ack_pulse");
        ack_pulse();
        check_outputs("ack_idle");

        // Second frame left unacknowledged.
        new_frame();
        wait_conv("f2");
        check("frame_spacing", 32'(conv_cyc - c0), 32'(SP));
        wait_vrise("f2");
        frame_done(1'b0);
        check_outputs("f2");

        // Ack lands exactly on the DONE cycle of the third frame.
        new_frame();
        wait_conv("f3");
        a = conv_cyc;
        wait_cyc(a + LAT - 1);
        sample_ack = 1'b1;
        @(negedge clk);
        sample_ack = 1'b0;
        frame_done(1'b1);
        check_outputs("simul_ack");

        // Fourth frame replaces an unacknowledged sample.
        new_frame();
        wait_conv("f4");
        a = conv_cyc;
        wait_cyc(a + LAT - 1);
        check_outputs("pre_load");
        wait_cyc(a + LAT);
        frame_done(1'b0);
        check_outputs("overrun");
        ack_pulse();
        check_outputs("overrun_sticky");

        // Asynchronous reset in the middle of SHIFT.
        new_frame();
        wait_conv("f5");
        a = conv_cyc;
        wait_cyc(a + 50);
        #2 rst = 1'b1;
        #1;
        exp_ch0 = '0; exp_ch1 = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
        check("midrst_ad_conv", 32'(ad_conv), 32'd0);
        check("midrst_sck", 32'(spi_sck), 32'd0);
        check_outputs("midrst");
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        r_cyc    = cyc;
        sck_base = sck_n;
        new_frame();
        wait_conv("f6");
        check("no_sck_after_rst", 32'(sck_n - sck_base), 32'd0);
        check("tick_after_rst", 32'(conv_cyc - r_cyc), 32'(SP));
        wait_vrise("f6");
        frame_done(1'b0);
        check_outputs("f6");
        ack_pulse();

        // Enable dropped during bit 10.
        new_frame();
        wait_conv("f7");
        sck_base = sck_n;
        k = 0;
        while (sck_n - sck_base < 10 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("bit10_reached", 32'(sck_n - sck_base), 32'd10);
        enable = 1'b0;
        wait_vrise("f7");
        frame_done(1'b0);
        check_outputs("en_drop");
        n = conv_n;
        repeat (5000) @(negedge clk);
        check("no_conv_after_disable", 32'(conv_n - n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
